// File: rtl/line_pulse_if.sv
// Receive-side line-code bus: code handshake in, decoded one-hot lines and status out.
interface line_pulse_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_none;
    logic [15:0] out_lines;
    logic        out_active;
    logic        busy;

    modport master (
        output in_valid, in_code, in_none,
        input  in_ready, out_lines, out_active, busy
    );

    modport slave (
        input  in_valid, in_code, in_none,
        output in_ready, out_lines, out_active, busy
    );
endinterface

// File: rtl/line_pulse_decoder.sv
// Buffers 4-bit line codes in a FIFO and replays each as a one-hot 16-line pulse
// of HOLD_CYCLES width, optionally followed by GAP_CYCLES of all-zero output.
module line_pulse_decoder #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic         clk,
    input  logic         rst,
    line_pulse_if.slave  bus
);

    localparam int unsigned LINES_W   = 16;
    localparam int unsigned ENTRY_W   = 5;
    localparam int unsigned MAX_HG    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned TW        = $clog2(MAX_HG + 1);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam int unsigned HOLD_LOAD = HOLD_CYCLES - 1;
    localparam int unsigned GAP_LOAD  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit          HAS_GAP   = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [LINES_W-1:0]   lines_q, lines_d;
    logic                 active_q, active_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [ENTRY_W-1:0]   fifo_q [FIFO_DEPTH];

    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   head;
    logic [LINES_W-1:0]   head_lines;

    // Ready depends on occupancy only, so a full FIFO never accepts even while popping.
    assign bus.in_ready = !rst && (count_q < CW'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    assign head       = fifo_q[rd_ptr_q];
    assign head_lines = head[4] ? '0 : (LINES_W'(1) << head[3:0]);

    assign bus.out_lines  = lines_q;
    assign bus.out_active = active_q;
    assign bus.busy       = (state_q != ST_IDLE) || (count_q != '0);

    // Pulse sequencer: pops the head entry when starting a pulse.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        lines_d  = lines_q;
        active_d = active_q;
        pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    lines_d  = head_lines;
                    active_d = 1'b1;
                    timer_d  = TW'(HOLD_LOAD);
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (HAS_GAP) begin
                    lines_d  = '0;
                    active_d = 1'b0;
                    timer_d  = TW'(GAP_LOAD);
                    state_d  = ST_GAP;
                end else if (count_q != '0) begin
                    pop      = 1'b1;
                    lines_d  = head_lines;
                    active_d = 1'b1;
                    timer_d  = TW'(HOLD_LOAD);
                end else begin
                    lines_d  = '0;
                    active_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            lines_q  <= '0;
            active_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            lines_q  <= lines_d;
            active_q <= active_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= {bus.in_none, bus.in_code};
        end
    end

endmodule

// File: tb/tb_line_pulse_decoder.sv
// Directed bench: default instance (gap 1) plus a zero-gap instance for back-to-back pulses.
module tb_line_pulse_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    line_pulse_if if_a ();
    line_pulse_if if_b ();

    line_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .FIFO_DEPTH(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    line_pulse_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records out_lines at every rising edge of out_active on the default instance.
    logic [15:0] seen_q[$];
    logic        prev_act_a = 1'b0;
    always @(posedge clk) begin
        #1;
        if (if_a.out_active === 1'b1 && prev_act_a === 1'b0) seen_q.push_back(if_a.out_lines);
        prev_act_a = if_a.out_active;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_idle_a(input string tag);
        int n;
        n = 0;
        while (if_a.busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(if_a.busy), 32'd0);
    endtask

    initial begin
        int  tries;
        bit  ready_dropped;
        int  replay;

        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_code = 4'h0; if_a.in_none = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_code = 4'h0; if_b.in_none = 1'b0;

        // 1: reset
        tick(); tick(); tick();
        chk("t1_ready_in_rst", 32'(if_a.in_ready), 32'd0);
        chk("t1_lines_rst", 32'(if_a.out_lines), 32'd0);
        chk("t1_active_rst", 32'(if_a.out_active), 32'd0);
        chk("t1_busy_rst", 32'(if_a.busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("t1_ready_after", 32'(if_a.in_ready), 32'd1);
        chk("t1_lines_after", 32'(if_a.out_lines), 32'd0);
        chk("t1_busy_after", 32'(if_a.busy), 32'd0);

        // 2: single code F
        if_a.in_valid = 1'b1; if_a.in_code = 4'hF; if_a.in_none = 1'b0;
        tick();
        if_a.in_valid = 1'b0;
        chk("t2_lat0_lines", 32'(if_a.out_lines), 32'd0);
        chk("t2_lat0_busy", 32'(if_a.busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_lines", 32'(if_a.out_lines), 32'h8000);
            chk("t2_hold_active", 32'(if_a.out_active), 32'd1);
        end
        tick();
        chk("t2_gap_lines", 32'(if_a.out_lines), 32'd0);
        chk("t2_gap_active", 32'(if_a.out_active), 32'd0);
        chk("t2_gap_busy", 32'(if_a.busy), 32'd1);
        tick();
        chk("t2_idle_busy", 32'(if_a.busy), 32'd0);

        // 3: six codes into a four-deep FIFO
        seen_q.delete();
        ready_dropped = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if_a.in_valid = 1'b1; if_a.in_code = 4'(c); if_a.in_none = 1'b0;
            tries = 0;
            while (if_a.in_ready !== 1'b1 && tries < 50) begin
                ready_dropped = 1'b1;
                tick();
                tries++;
            end
            chk("t3_accept_bound", 32'(if_a.in_ready), 32'd1);
            tick();
        end
        if_a.in_valid = 1'b0;
        chk("t3_ready_dropped", 32'(ready_dropped), 32'd1);
        wait_idle_a("t3_drain_timeout");
        chk("t3_count", 32'(seen_q.size()), 32'd6);
        for (int c = 0; c < 6; c++) begin
            logic [15:0] exp_l;
            exp_l = 16'h0001 << c;
            if (c < seen_q.size()) chk("t3_order", 32'(seen_q[c]), 32'(exp_l));
        end

        // 4: none-pulse
        if_a.in_valid = 1'b1; if_a.in_code = 4'h7; if_a.in_none = 1'b1;
        tick();
        if_a.in_valid = 1'b0; if_a.in_none = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_none_active", 32'(if_a.out_active), 32'd1);
            chk("t4_none_lines", 32'(if_a.out_lines), 32'd0);
        end
        tick();
        chk("t4_none_end", 32'(if_a.out_active), 32'd0);
        wait_idle_a("t4_idle_timeout");

        // 5: zero gap, back-to-back 3 then 9
        if_b.in_valid = 1'b1; if_b.in_code = 4'h3; if_b.in_none = 1'b0;
        tick();
        chk("t5_lat0", 32'(if_b.out_lines), 32'd0);
        if_b.in_code = 4'h9;
        tick();
        if_b.in_valid = 1'b0;
        chk("t5_first", 32'(if_b.out_lines), 32'h0008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_first", 32'(if_b.out_lines), 32'h0008);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_second", 32'(if_b.out_lines), 32'h0200);
            chk("t5_second_act", 32'(if_b.out_active), 32'd1);
        end
        tick();
        chk("t5_end_lines", 32'(if_b.out_lines), 32'd0);
        chk("t5_end_busy", 32'(if_b.busy), 32'd0);

        // 6: reset in second HOLD cycle with two codes queued
        if_a.in_valid = 1'b1; if_a.in_none = 1'b0;
        if_a.in_code = 4'h1; tick();
        if_a.in_code = 4'h2; tick();
        chk("t6_hold1", 32'(if_a.out_lines), 32'h0002);
        if_a.in_code = 4'h3; tick();
        if_a.in_valid = 1'b0;
        chk("t6_hold2", 32'(if_a.out_lines), 32'h0002);
        rst = 1'b1;
        tick();
        chk("t6_rst_lines", 32'(if_a.out_lines), 32'd0);
        chk("t6_rst_busy", 32'(if_a.busy), 32'd0);
        chk("t6_rst_ready", 32'(if_a.in_ready), 32'd0);
        rst = 1'b0;
        replay = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_a.out_active !== 1'b0 || if_a.out_lines !== 16'h0) replay++;
        end
        chk("t6_no_replay", 32'(replay), 32'd0);
        chk("t6_idle_busy", 32'(if_a.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
